seq_shifter_unit: RTL and testbench
===================================

# seq_shifter_unit

Multi-cycle, parametrised shifter for the datapath: general successor to the fixed two-bit left shifter used for jump-target formation. Accepts an operand, shift amount and mode over a valid/ready handshake. Shifts by up to STEP bits per clock, then holds the result until the consumer accepts it. It serves jump/branch address formation, the ALU shift path and normalisation without a full combinational barrel shifter.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 4.
- STEP, 4: maximum bits shifted per cycle; 1 ≤ STEP ≤ WIDTH.
- AMT_W, 6: width of ShiftAmt; must satisfy 2^AMT_W > WIDTH.
- Clk  input  1  rising-edge clock, single clock domain.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  request valid.
- InReady  output  1  block can accept a request.
- ValueIn  input  WIDTH  operand.
- ShiftAmt  input  AMT_W  shift amount, unsigned.
- Mode  input  2  shift mode:
  - 00: logical left.
  - 01: logical right.
  - 10: arithmetic right.
  - 11: rotate left.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts the result.
- ValueOut  output  WIDTH  result, registered.
- Sticky  output  1  OR of all bits shifted out. Present only with SHIFTER_STICKY_EN.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **Reset:** state = IDLE. Outputs after reset: InReady = 1, OutValid = 0, ValueOut = 0, Sticky = 0.
- **IDLE:**
  - InReady = 1.
  - On InValid && InReady, the block captures ValueIn, Mode and the effective amount Rem:
    - Modes 00/01/10: Rem = min(ShiftAmt, WIDTH).
    - Mode 11: Rem = ShiftAmt mod WIDTH.
  - Next state is SHIFT if Rem > 0, else DONE.
- **SHIFT:**
  - Each cycle applies s = min(STEP, Rem) to the working register and sets Rem -= s.
  - Fill rules:
    - Logical modes fill with 0.
    - Arithmetic right fills with the captured sign bit.
    - Rotate wraps.
  - Goes to DONE on the cycle Rem becomes 0.
- **Out-of-range amounts:** an amount ≥ WIDTH yields 0 for logical modes and all-sign for arithmetic right.
- **DONE:**
  - OutValid = 1. ValueOut (and Sticky) hold stable until OutValid && OutReady.
  - Returns to IDLE on that edge.
- **Signal rules:**
  - InReady is 0 in SHIFT and DONE. InValid is ignored there.
  - ValueOut reflects the working register. It is only meaningful while OutValid = 1.
- **Reset mid-operation** (any state): the operation is abandoned and no result is produced. All outputs take their reset values on the next edge.
- **Simultaneous events:** OutReady asserted in IDLE or SHIFT has no effect.

## Timing
- Acceptance edge is T0.
- OutValid rises after edge T0 + ceil(Rem/STEP). For Rem = 0 it rises after T0 itself, i.e. visible in the first cycle after acceptance.
- The result handshake consumes one further edge.
- The next request can be accepted no earlier than the cycle after the result handshake.
- Throughput: one operation per ceil(Rem/STEP) + 2 cycles. No back-to-back overlap.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- **SHIFTER_STICKY_EN defined:**
  - Sticky port exists. It clears at acceptance.
  - It ORs in every bit shifted out during SHIFT: MSB-side bits for mode 00, LSB-side bits for modes 01/10.
  - It stays 0 for mode 11.
  - It is valid with OutValid and held with ValueOut.
- **SHIFTER_STICKY_EN undefined:**
  - No Sticky port and no sticky logic.
  - All other behaviour is identical.

## Test plan
All scenarios use defaults: WIDTH = 32, STEP = 4.
- **Jump-target case:** Mode 00, ValueIn = 0x03FF_FFFF, ShiftAmt = 2 → ValueOut = 0x0FFF_FFFC. OutValid after T0+1.
- **Arithmetic fill:** Mode 10, ValueIn = 0x8000_0000, ShiftAmt = 31 → ValueOut = 0xFFFF_FFFF. OutValid after T0+8. ShiftAmt = 40 gives the same result.
- **Rotate wrap:** Mode 11, ValueIn = 0x8000_0001, ShiftAmt = 36 → ValueOut = 0x0000_0018. OutValid after T0+1.
- **Zero amount with backpressure:** ShiftAmt = 0, ValueIn = 0x1234_5678 → ValueOut = 0x1234_5678 after T0. Hold OutReady = 0 for 5 cycles: OutValid stays 1, ValueOut is stable, InReady = 0. Raise OutReady: IDLE, then InReady = 1.
- **Reset mid-SHIFT:** Mode 01, ShiftAmt = 20, assert Reset at T0+2 → next cycle OutValid = 0, ValueOut = 0, InReady = 1. No result ever appears.
- **Sticky (SHIFTER_STICKY_EN):**
  - Mode 01, 0x0000_0011, ShiftAmt = 4 → ValueOut = 0x1, Sticky = 1.
  - Mode 01, 0x0000_0010, ShiftAmt = 4 → ValueOut = 0x1, Sticky = 0.

Source files
------------

// File: rtl/seq_shifter_unit.sv
// Multi-cycle shifter: applies up to STEP bits per clock and then holds the result until taken.
// Define SHIFTER_STICKY_EN to add the Sticky output (OR of every bit shifted out).
module seq_shifter_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AMT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] ValueIn,
  input  logic [AMT_W-1:0] ShiftAmt,
  input  logic [1:0]       Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ValueOut
`ifdef SHIFTER_STICKY_EN
  ,
  output logic             Sticky
`endif
);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;
  localparam logic [1:0] ModeRol = 2'b11;

  localparam logic [AMT_W-1:0] WidthAmt = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] WidthMask = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] StepAmt = AMT_W'(STEP);
  localparam logic [WIDTH-1:0] AllOnes = '1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           stateQ, stateD;
  logic [WIDTH-1:0] workQ, workD;
  logic [AMT_W-1:0] remQ, remD;
  logic [1:0]       modeQ, modeD;
  logic             signQ, signD;

  logic             accept;
  logic [AMT_W-1:0] capAmt;
  logic [AMT_W-1:0] stepAmt;
  logic [WIDTH-1:0] shifted;

  assign accept = (stateQ == StIdle) && InValid;

  // Rotate only needs the amount modulo WIDTH; other modes saturate at WIDTH (all bits gone).
  always_comb begin
    if (Mode == ModeRol) begin
      capAmt = ShiftAmt & WidthMask;
    end else begin
      capAmt = (ShiftAmt > WidthAmt) ? WidthAmt : ShiftAmt;
    end
  end

  assign stepAmt = (remQ > StepAmt) ? StepAmt : remQ;

  always_comb begin
    case (modeQ)
      ModeSll: shifted = workQ << stepAmt;
      ModeSrl: shifted = workQ >> stepAmt;
      ModeSra: shifted = (workQ >> stepAmt) | (signQ ? ~(AllOnes >> stepAmt) : '0);
      default: shifted = (workQ << stepAmt) | (workQ >> (WidthAmt - stepAmt));
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle: begin
        if (InValid) begin
          stateD = (capAmt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (remQ <= StepAmt) begin
          stateD = StDone;
        end
      end
      StDone: begin
        if (OutReady) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Output decode: everything comes from state or registers, never from inputs.
  always_comb begin
    InReady  = (stateQ == StIdle);
    OutValid = (stateQ == StDone);
    ValueOut = workQ;
  end

  always_comb begin
    workD = workQ;
    remD  = remQ;
    modeD = modeQ;
    signD = signQ;
    if (accept) begin
      workD = ValueIn;
      remD  = capAmt;
      modeD = Mode;
      signD = ValueIn[WIDTH-1];
    end else if (stateQ == StShift) begin
      workD = shifted;
      remD  = remQ - stepAmt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      workQ <= '0;
      remQ  <= '0;
      modeQ <= ModeSll;
      signQ <= 1'b0;
    end else begin
      workQ <= workD;
      remQ  <= remD;
      modeQ <= modeD;
      signQ <= signD;
    end
  end

`ifdef SHIFTER_STICKY_EN
  logic stickyQ, stickyD;
  logic lostBits;

  // Bits leaving the register this cycle: top stepAmt bits for left, bottom ones for right.
  always_comb begin
    case (modeQ)
      ModeSll:          lostBits = |(workQ & ~(AllOnes >> stepAmt));
      ModeSrl, ModeSra: lostBits = |(workQ & ~(AllOnes << stepAmt));
      default:          lostBits = 1'b0;
    endcase
  end

  always_comb begin
    stickyD = stickyQ;
    if (accept) begin
      stickyD = 1'b0;
    end else if (stateQ == StShift) begin
      stickyD = stickyQ | lostBits;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stickyQ <= 1'b0;
    end else begin
      stickyQ <= stickyD;
    end
  end

  assign Sticky = stickyQ;
`endif

endmodule

// File: tb/tb_seq_shifter_unit.sv
// Directed self-checking bench for seq_shifter_unit at WIDTH=32, STEP=4.
// Sticky checks are compiled in when SHIFTER_STICKY_EN is defined.
module tb_seq_shifter_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 4;
  localparam int unsigned AMT_W = 6;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] ValueIn;
  logic [AMT_W-1:0] ShiftAmt;
  logic [1:0]       Mode;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ValueOut;
`ifdef SHIFTER_STICKY_EN
  logic             Sticky;
`endif

  int errors = 0;
  int checks = 0;

  seq_shifter_unit #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .AMT_W(AMT_W)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .InValid (InValid),
    .InReady (InReady),
    .ValueIn (ValueIn),
    .ShiftAmt(ShiftAmt),
    .Mode    (Mode),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .ValueOut(ValueOut)
`ifdef SHIFTER_STICKY_EN
    ,
    .Sticky  (Sticky)
`endif
  );

  always #5 Clk = ~Clk;

  // Present a request for one edge (T0); returns 1ns after T0 with junk on the request bus.
  task automatic start_op(input logic [1:0] m, input logic [31:0] v, input logic [5:0] a);
    InValid  = 1'b1;
    Mode     = m;
    ValueIn  = v;
    ShiftAmt = a;
    @(posedge Clk);
    #1;
    InValid  = 1'b0;
    ValueIn  = 32'hDEAD_BEEF;
    ShiftAmt = 6'd63;
    Mode     = 2'b10;
  endtask

  // Count edges after T0 until OutValid is seen; bounded at 64.
  task automatic wait_done(output int lat);
    lat = 0;
    while (OutValid !== 1'b1 && lat < 64) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op;
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset;
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    ValueIn  = '0;
    ShiftAmt = '0;
    Mode     = 2'b00;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready: got %b expected 1", InReady);
    end
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outvalid: got %b expected 0", OutValid);
    end
    checks++;
    if (ValueOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_valueout: got %h expected 00000000", ValueOut);
    end
`ifdef SHIFTER_STICKY_EN
    checks++;
    if (Sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky: got %b expected 0", Sticky);
    end
`endif
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_jump_target;
    int lat;
    start_op(2'b00, 32'h03FF_FFFF, 6'd2);
    wait_done(lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL jump_latency: got %0d expected 1", lat);
    end
    checks++;
    if (ValueOut !== 32'h0FFF_FFFC) begin
      errors++;
      $display("FAIL jump_value: got %h expected 0ffffffc", ValueOut);
    end
    finish_op();
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL jump_release: got InReady=%b OutValid=%b expected 1/0", InReady, OutValid);
    end
  endtask

  task automatic test_arith_fill;
    int lat;
    logic [5:0] amts [2] = '{6'd31, 6'd40};
    for (int i = 0; i < 2; i++) begin
      start_op(2'b10, 32'h8000_0000, amts[i]);
      // A competing request during the operation must be ignored.
      InValid = 1'b1;
      ValueIn = 32'h0000_0000;
      Mode    = 2'b00;
      wait_done(lat);
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got %0d expected 8", i, lat);
      end
      checks++;
      if (ValueOut !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL arith_value[%0d]: got %h expected ffffffff", i, ValueOut);
      end
      InValid = 1'b0;
      finish_op();
    end
  endtask

  task automatic test_rotate_wrap;
    int lat;
    start_op(2'b11, 32'h8000_0001, 6'd36);
    wait_done(lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL rotate_latency: got %0d expected 1", lat);
    end
    checks++;
    if (ValueOut !== 32'h0000_0018) begin
      errors++;
      $display("FAIL rotate_value: got %h expected 00000018", ValueOut);
    end
    finish_op();
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(2'b00, 32'h1234_5678, 6'd0);
    wait_done(lat);
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 0", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk);
      #1;
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || ValueOut !== 32'h1234_5678) begin
        errors++;
        $display("FAIL hold[%0d]: got OutValid=%b InReady=%b ValueOut=%h expected 1/0/12345678",
                 c, OutValid, InReady, ValueOut);
      end
    end
    finish_op();
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got InReady=%b OutValid=%b expected 1/0", InReady, OutValid);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic seen;
    start_op(2'b01, 32'hFFFF_0000, 6'd20);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || ValueOut !== 32'h0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL midreset: got OutValid=%b ValueOut=%h InReady=%b expected 0/00000000/1",
               OutValid, ValueOut, InReady);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge Clk);
      #1;
      if (OutValid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_noresult: got OutValid seen=%b expected 0", seen);
    end
  endtask

  // Back-to-back operations, each started on the cycle after the previous handshake.
  task automatic test_back_to_back;
    int lat;
    logic [1:0]  tMode [8] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01};
    logic [31:0] tVal  [8] = '{32'hF000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                               32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_000F, 32'h1234_5678};
    logic [5:0]  tAmt  [8] = '{6'd8, 6'd4, 6'd5, 6'd40, 6'd32, 6'd63, 6'd31, 6'd32};
    logic [31:0] tExp  [8] = '{32'h00F0_0000, 32'hF800_0000, 32'h07FF_FFFF, 32'h0000_0000,
                               32'h1234_5678, 32'h0000_0000, 32'h8000_0007, 32'h0000_0000};
    int          tLat  [8] = '{2, 1, 2, 8, 0, 8, 8, 8};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (InReady !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, InReady);
      end
      start_op(tMode[i], tVal[i], tAmt[i]);
      wait_done(lat);
      checks++;
      if (lat != tLat[i] || ValueOut !== tExp[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got lat=%0d value=%h expected lat=%0d value=%h",
                 i, lat, ValueOut, tLat[i], tExp[i]);
      end
      finish_op();
    end
  endtask

`ifdef SHIFTER_STICKY_EN
  task automatic test_sticky;
    int lat;
    logic [1:0]  sMode [4] = '{2'b01, 2'b01, 2'b00, 2'b11};
    logic [31:0] sVal  [4] = '{32'h0000_0011, 32'h0000_0010, 32'h8000_0000, 32'h8000_0001};
    logic [5:0]  sAmt  [4] = '{6'd4, 6'd4, 6'd1, 6'd4};
    logic [31:0] sExp  [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0018};
    logic        sStk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      start_op(sMode[i], sVal[i], sAmt[i]);
      wait_done(lat);
      checks++;
      if (lat != 1 || ValueOut !== sExp[i] || Sticky !== sStk[i]) begin
        errors++;
        $display("FAIL sticky[%0d]: got lat=%0d value=%h sticky=%b expected 1/%h/%b",
                 i, lat, ValueOut, Sticky, sExp[i], sStk[i]);
      end
      finish_op();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_jump_target();
    test_arith_fill();
    test_rotate_wrap();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
`ifdef SHIFTER_STICKY_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
